// File: rtl/sbox_pkg.sv
// Shared types and helpers for the N-to-1 buffered switch.
// Holds the FSM state encoding and the select-width function.
package sbox_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sbox_fifo2.sv
// Two-entry FIFO with head/tail registers.
// A read and a write in the same cycle keep the count unchanged.
module sbox_fifo2 #(
    parameter int SIZE = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            wr,
    input  logic [SIZE-1:0] wr_data,
    input  logic            rd,
    output logic            full,
    output logic            empty,
    output logic [1:0]      count,
    output logic [SIZE-1:0] rd_data
);

    logic [SIZE-1:0] head_q, head_d;
    logic [SIZE-1:0] tail_q, tail_d;
    logic [1:0]      count_q, count_d;
    logic            do_wr, do_rd;

    always_comb begin
        do_rd   = rd && (count_q != 2'd0);
        do_wr   = wr && (count_q != 2'd2);
        head_d  = head_q;
        tail_d  = tail_q;
        if (do_rd) head_d = tail_q;
        // The new word lands in whichever slot is the first free one after the read.
        if (do_wr) begin
            if (count_q == 2'd0 || (count_q == 2'd1 && do_rd))
                head_d = wr_data;
            else
                tail_d = wr_data;
        end
        count_d = count_q + {1'b0, do_wr} - {1'b0, do_rd};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign count   = count_q;
    assign rd_data = head_q;

endmodule

// File: rtl/sbox_nx1_buf.sv
// N-to-1 buffered channel switch; a select change drains the
// buffer before the new channel is routed.
import sbox_pkg::*;

module sbox_nx1_buf #(
    parameter  int SIZE       = 32,
    parameter  int N          = 4,
    parameter  int UNSEL_FULL = 1,
    localparam int SELW       = sel_width(N)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N*SIZE-1:0] in_data,
    input  logic [N-1:0]      in_wr,
    output logic [N-1:0]      in_full,
    output logic [SIZE-1:0]   out1_data,
    output logic              out1_wr,
    input  logic              out1_full,
    input  logic [SELW-1:0]   sel,
    output logic [SELW-1:0]   sel_active,
    output logic              busy
);

    localparam logic [SELW:0] N_W = (SELW+1)'(N);

    state_e          state_q, state_d;
    logic [SELW-1:0] sel_active_q, sel_active_d;
    logic [SIZE-1:0] mux_data;
    logic            mux_wr;
    logic            fifo_full, fifo_empty;
    logic [1:0]      fifo_count;
    logic            sel_ok, drain_done;

    assign sel_ok = ({1'b0, sel} < N_W);

    // Backpressure depends on registered state only.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (SELW'(i) == sel_active_q)
                in_full[i] = fifo_full || (state_q != ST_RUN);
            else if (state_q == ST_DRAIN)
                in_full[i] = 1'b1;
            else
                in_full[i] = (UNSEL_FULL != 0);
        end
    end

    always_comb begin
        mux_data = in_data[int'(sel_active_q)*SIZE +: SIZE];
        mux_wr   = in_wr[sel_active_q] && !in_full[sel_active_q];
    end

    sbox_fifo2 #(.SIZE(SIZE)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr      (mux_wr),
        .wr_data (mux_data),
        .rd      (out1_wr),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .rd_data (out1_data)
    );

    assign out1_wr = !fifo_empty && !out1_full;

    always_comb begin
        state_d      = state_q;
        sel_active_d = sel_active_q;
        drain_done   = (fifo_count == 2'd0) ||
                       (fifo_count == 2'd1 && out1_wr);
        case (state_q)
            ST_RUN: begin
                if (sel_ok && sel != sel_active_q)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_d = ST_RUN;
                    if (sel_ok) sel_active_d = sel;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_RUN;
            sel_active_q <= '0;
        end else begin
            state_q      <= state_d;
            sel_active_q <= sel_active_d;
        end
    end

    assign sel_active = sel_active_q;
    assign busy       = (state_q == ST_DRAIN);

endmodule

// File: tb/tb_sbox_nx1_buf.sv
// Directed bench for sbox_nx1_buf with an output scoreboard.
// Three instances cover N=4, N=6 with UNSEL_FULL=0, and N=8.
module tb_sbox_nx1_buf;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [127:0] in_data;
    logic [3:0]   in_wr, in_full;
    logic [31:0]  out1_data;
    logic         out1_wr, out1_full, busy;
    logic [1:0]   sel, sel_active;

    logic [191:0] in_data_b;
    logic [5:0]   in_wr_b, in_full_b;
    logic [31:0]  out1_data_b;
    logic         out1_wr_b, busy_b;
    logic [2:0]   sel_b, sel_active_b;

    logic [255:0] in_data_c;
    logic [7:0]   in_wr_c, in_full_c;
    logic [31:0]  out1_data_c;
    logic         out1_wr_c, busy_c;
    logic [2:0]   sel_c, sel_active_c;

    sbox_nx1_buf #(.SIZE(32), .N(4), .UNSEL_FULL(1)) dut (
        .clock(clk), .reset(reset), .in_data(in_data), .in_wr(in_wr),
        .in_full(in_full), .out1_data(out1_data), .out1_wr(out1_wr),
        .out1_full(out1_full), .sel(sel), .sel_active(sel_active),
        .busy(busy)
    );

    sbox_nx1_buf #(.SIZE(32), .N(6), .UNSEL_FULL(0)) dut_b (
        .clock(clk), .reset(reset), .in_data(in_data_b), .in_wr(in_wr_b),
        .in_full(in_full_b), .out1_data(out1_data_b), .out1_wr(out1_wr_b),
        .out1_full(1'b0), .sel(sel_b), .sel_active(sel_active_b),
        .busy(busy_b)
    );

    sbox_nx1_buf #(.SIZE(32), .N(8), .UNSEL_FULL(1)) dut_c (
        .clock(clk), .reset(reset), .in_data(in_data_c), .in_wr(in_wr_c),
        .in_full(in_full_c), .out1_data(out1_data_c), .out1_wr(out1_wr_c),
        .out1_full(1'b0), .sel(sel_c), .sel_active(sel_active_c),
        .busy(busy_c)
    );

    int total  = 0;
    int passed = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    // Scoreboard: every emitted word must match the oldest expected one.
    always @(negedge clk) begin
        if (!reset && out1_wr) begin
            if (exp_q.size() == 0)
                chk("unexpected_out1_wr", 32'd1, 32'd0);
            else
                chk("out1_data", out1_data, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; out1_full = 1'b0;
        in_data = '0; in_wr = '0; sel = 2'd0;
        in_data_b = '0; in_wr_b = '0; sel_b = 3'd0;
        in_data_c = '0; in_wr_c = '0; sel_c = 3'd0;

        @(negedge clk);
        chk("rst_out1_wr", 32'(out1_wr), 32'd0);
        chk("rst_in_full", 32'(in_full), 32'h0E);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sel_active", 32'(sel_active), 32'd0);
        chk("rst_in_full_b", 32'(in_full_b), 32'h00);
        chk("rst_in_full_c", 32'(in_full_c), 32'hFE);
        step;
        reset = 1'b0;

        // Streaming: three back-to-back words on channel 0.
        in_wr = 4'b0001; in_data[31:0] = 32'hA; exp_q.push_back(32'hA);
        @(negedge clk);
        chk("lat_idle", 32'(out1_wr), 32'd0);
        chk("s_in_full0", 32'(in_full[0]), 32'd0);
        step;
        in_data[31:0] = 32'hB; exp_q.push_back(32'hB);
        @(negedge clk);
        chk("lat_a", 32'(out1_wr), 32'd1);
        chk("s_in_full0", 32'(in_full[0]), 32'd0);
        step;
        in_data[31:0] = 32'hC; exp_q.push_back(32'hC);
        @(negedge clk);
        chk("lat_b", 32'(out1_wr), 32'd1);
        chk("s_in_full0", 32'(in_full[0]), 32'd0);
        step;
        in_wr = '0;
        @(negedge clk);
        chk("lat_c", 32'(out1_wr), 32'd1);
        step;
        @(negedge clk);
        chk("stream_end", 32'(out1_wr), 32'd0);

        // Backpressure: third word refused while buffer holds two.
        step;
        out1_full = 1'b1;
        in_wr = 4'b0001; in_data[31:0] = 32'h11; exp_q.push_back(32'h11);
        @(negedge clk);
        chk("bp_full_0", 32'(in_full[0]), 32'd0);
        step;
        in_data[31:0] = 32'h22; exp_q.push_back(32'h22);
        @(negedge clk);
        chk("bp_full_1", 32'(in_full[0]), 32'd0);
        chk("bp_no_wr", 32'(out1_wr), 32'd0);
        step;
        in_data[31:0] = 32'h33;
        @(negedge clk);
        chk("bp_full_2", 32'(in_full[0]), 32'd1);
        step;
        in_wr = '0;
        @(negedge clk);
        chk("bp_full_3", 32'(in_full[0]), 32'd1);
        step;
        out1_full = 1'b0;
        @(negedge clk);
        chk("bp_rel_a", 32'(out1_wr), 32'd1);
        step;
        @(negedge clk);
        chk("bp_rel_b", 32'(out1_wr), 32'd1);
        step;
        @(negedge clk);
        chk("bp_empty", 32'(out1_wr), 32'd0);

        // Reconfiguration with two words buffered.
        step;
        out1_full = 1'b1;
        in_wr = 4'b0001; in_data[31:0] = 32'h44; exp_q.push_back(32'h44);
        step;
        in_data[31:0] = 32'h55; exp_q.push_back(32'h55);
        step;
        in_wr = '0; sel = 2'd2;
        @(negedge clk);
        chk("rc_pre_busy", 32'(busy), 32'd0);
        step;
        @(negedge clk);
        chk("rc_busy", 32'(busy), 32'd1);
        chk("rc_all_full", 32'(in_full), 32'h0F);
        step;
        out1_full = 1'b0;
        @(negedge clk);
        chk("rc_drain_wr1", 32'(out1_wr), 32'd1);
        chk("rc_busy1", 32'(busy), 32'd1);
        step;
        @(negedge clk);
        chk("rc_drain_wr2", 32'(out1_wr), 32'd1);
        chk("rc_busy2", 32'(busy), 32'd1);
        step;
        @(negedge clk);
        chk("rc_done_busy", 32'(busy), 32'd0);
        chk("rc_sel_active", 32'(sel_active), 32'd2);
        chk("rc_in_full", 32'(in_full), 32'h0B);
        chk("rc_idle", 32'(out1_wr), 32'd0);
        in_wr = 4'b0101;
        in_data[31:0] = 32'hDEAD; in_data[95:64] = 32'h66;
        exp_q.push_back(32'h66);
        step;
        in_wr = '0;
        @(negedge clk);
        chk("rc_ch2_routed", 32'(out1_wr), 32'd1);
        step;

        // Select range: 7 ignored on N=6, 5 valid on N=8.
        sel_b = 3'd7; sel_c = 3'd5;
        @(negedge clk);
        chk("rng_c_busy0", 32'(busy_c), 32'd0);
        step;
        @(negedge clk);
        chk("rng_c_busy1", 32'(busy_c), 32'd1);
        chk("rng_c_full", 32'(in_full_c), 32'hFF);
        chk("rng_b_busy", 32'(busy_b), 32'd0);
        step;
        @(negedge clk);
        chk("rng_c_sel", 32'(sel_active_c), 32'd5);
        chk("rng_c_busy2", 32'(busy_c), 32'd0);
        chk("rng_c_full2", 32'(in_full_c), 32'hDF);
        chk("rng_b_sel", 32'(sel_active_b), 32'd0);
        chk("rng_b_busy2", 32'(busy_b), 32'd0);

        // Unselected writes discarded when UNSEL_FULL=0.
        step;
        in_wr_b = 6'b000010; in_data_b[63:32] = 32'h77;
        @(negedge clk);
        chk("us_full1", 32'(in_full_b[1]), 32'd0);
        step;
        @(negedge clk);
        chk("us_no_wr1", 32'(out1_wr_b), 32'd0);
        chk("us_full_all", 32'(in_full_b), 32'h00);
        step;
        in_wr_b = '0;
        @(negedge clk);
        chk("us_no_wr2", 32'(out1_wr_b), 32'd0);

        // Reset in the middle of a drain with one word buffered.
        step;
        out1_full = 1'b1;
        in_wr = 4'b0100; in_data[95:64] = 32'h88;
        step;
        in_wr = '0; sel = 2'd0;
        step;
        @(negedge clk);
        chk("mr_busy", 32'(busy), 32'd1);
        chk("mr_hold", 32'(out1_wr), 32'd0);
        step;
        reset = 1'b1;
        step;
        reset = 1'b0; out1_full = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mr_out1_wr", 32'(out1_wr), 32'd0);
        chk("mr_sel_active", 32'(sel_active), 32'd0);
        chk("mr_busy0", 32'(busy), 32'd0);
        chk("mr_in_full", 32'(in_full), 32'h0E);
        step;
        @(negedge clk);
        chk("mr_still_idle", 32'(out1_wr), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sbox_nx1_buf.md
SBOX_NX1_BUF -- requirements
Module: sbox_nx1_buf

Interface
REQ-001 Parameter SIZE, default 32: data width per channel in bits.
REQ-002 Parameter N, default 4: number of input channels, legal range 2..16.
REQ-003 Parameter UNSEL_FULL, default 1: 1 = unselected inputs see full=1; 0 = unselected inputs see full=0 and their writes are discarded.
REQ-004 Derived constant SELW = max(1, clog2(N)).
REQ-005 clock, input, 1: single clock; all state updates on its rising edge.
REQ-006 reset, input, 1: synchronous, active-high reset.
REQ-007 in_data, input, N*SIZE: channel i occupies bits [i*SIZE +: SIZE].
REQ-008 in_wr, input, N: per-channel write strobe.
REQ-009 in_full, output, N: per-channel backpressure.
REQ-010 out1_data, output, SIZE: head-of-buffer data.
REQ-011 out1_wr, output, 1: output write strobe.
REQ-012 out1_full, input, 1: downstream backpressure.
REQ-013 sel, input, SELW: requested channel.
REQ-014 sel_active, output, SELW: channel currently routed.
REQ-015 busy, output, 1: high while a reconfiguration drain is in progress.

Function
REQ-016 A write on channel i SHALL be accepted iff in_wr[i]=1 and in_full[i]=0 on the same edge.
REQ-017 An accepted word SHALL be stored in a 2-entry FIFO (count 0..2).
REQ-018 Write rule: out1_wr = (count!=0) && !out1_full; out1_data = FIFO head; out1_data is don't-care when count=0.
REQ-019 in_full[sel_active] SHALL equal (count==2) || (state!=RUN), derived from registers only.
REQ-020 For i != sel_active, in_full[i] SHALL equal UNSEL_FULL.
REQ-021 Latency: a word accepted at edge t SHALL be presented with out1_wr=1 in the cycle after edge t, provided count was 0 and out1_full=0.
REQ-022 A simultaneous accept and output write SHALL leave count unchanged, sustaining 1 word/cycle.
REQ-023 States: RUN and DRAIN.
REQ-024 RUN -> DRAIN when sel < N and sel != sel_active.
REQ-025 DRAIN: all in_full=1 and busy=1; the FIFO keeps emitting.
REQ-026 DRAIN -> RUN on the edge where count==0 (including a count that reaches 0 on that edge); sel_active loads the current sel on that edge if sel < N, otherwise it is unchanged.
REQ-027 sel >= N SHALL be ignored and SHALL NOT trigger DRAIN.
REQ-028 sel returning to sel_active during DRAIN SHALL still complete the drain, then stay on the same channel.
REQ-029 Word ordering SHALL be preserved; no word is dropped or duplicated, except discarded unselected writes when UNSEL_FULL=0.

Reset
REQ-030 On reset=1 at an edge: state=RUN, count=0, sel_active=0, busy=0; FIFO contents are discarded, including mid-drain.
REQ-031 During and immediately after reset: out1_wr=0, in_full[0]=0, and other in_full bits equal UNSEL_FULL.

Structure
REQ-032 State encodings and SELW computation SHALL live in the shared package/header sbox_pkg.
REQ-033 The 2-entry buffer SHALL be a sub-module, sbox_fifo2 (parameter SIZE; ports: wr, full, rd, empty, count, data in/out).
REQ-034 The input mux and FSM SHALL remain in sbox_nx1_buf.

Verification
REQ-035 N=4, sel=0, out1_full=0; write 0xA, 0xB, 0xC on ch0 on consecutive cycles -> out1_wr high for 3 cycles starting 1 cycle later, data A, B, C; in_full[0] stays 0.
REQ-036 out1_full=1; write 3 words on ch0 -> in_full[0]=1 after the 2nd accept, 3rd write not accepted; release out1_full -> A, B emitted in order.
REQ-037 count=2, sel 0->2 -> busy=1 and all in_full=1; after 2 out1_wr pulses busy=0, sel_active=2, in_full[2]=0, a ch2 word is routed.
REQ-038 sel=5 with N=8 is valid; sel=7 with N=6 -> no DRAIN, sel_active unchanged.
REQ-039 UNSEL_FULL=0: ch1 writes while sel_active=0 -> in_full[1]=0, no out1_wr, no FIFO growth.
REQ-040 reset asserted during DRAIN with count=1 -> next cycle out1_wr=0, sel_active=0, busy=0.
